mask_scan_streamer: RTL and testbench

//  Producer side of the centroid pixel stream. Raster-scans a 1-bit-per-pixel detection mask held in a

---
 rtl/mask_scan_streamer.sv | 137 +++++++++++++
 tb/tb_mask_scan_streamer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mask_scan_streamer.sv
// Raster-scans a 1-bit detection mask in frame BRAM and streams (x,y) of every set pixel,
// then strobes tabulate_out once per frame with the frame's set-pixel count.
module mask_scan_streamer #(
  parameter int WIDTH        = 1024,
  parameter int HEIGHT       = 768,
  parameter int READ_LATENCY = 2,
  localparam int ADDR_W      = $clog2(WIDTH * HEIGHT)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_data_in,
  output logic [10:0]       x_out,
  output logic [9:0]        y_out,
  output logic              valid_out,
  output logic              tabulate_out,
  output logic              busy_out,
  output logic [ADDR_W:0]   pixel_count_out
);

  localparam int DRAIN_W = $clog2(READ_LATENCY + 2);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [10:0]        LAST_X    = 11'(WIDTH - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(READ_LATENCY);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, TAB} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [10:0]         x_reg;
  logic [9:0]          y_reg;
  logic [DRAIN_W-1:0]  drain_reg;
  logic [ADDR_W:0]     count_reg;

  // Tag pipeline: stage i holds the coordinates of the address issued i+1 cycles ago,
  // so the last stage lines up with mem_data_in.
  logic [10:0] tag_x_reg    [READ_LATENCY];
  logic [9:0]  tag_y_reg    [READ_LATENCY];
  logic        tag_live_reg [READ_LATENCY];

  logic hit_next;
  assign hit_next = tag_live_reg[READ_LATENCY-1] & mem_data_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_x_reg[i]    <= '0;
        tag_y_reg[i]    <= '0;
        tag_live_reg[i] <= 1'b0;
      end
    end else begin
      tag_x_reg[0]    <= x_reg;
      tag_y_reg[0]    <= y_reg;
      tag_live_reg[0] <= (state_reg == SCAN);
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_x_reg[i]    <= tag_x_reg[i-1];
        tag_y_reg[i]    <= tag_y_reg[i-1];
        tag_live_reg[i] <= tag_live_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      drain_reg       <= '0;
      count_reg       <= '0;
      x_out           <= '0;
      y_out           <= '0;
      valid_out       <= 1'b0;
      tabulate_out    <= 1'b0;
      busy_out        <= 1'b0;
      pixel_count_out <= '0;
    end else begin
      valid_out <= hit_next;
      if (hit_next) begin
        x_out     <= tag_x_reg[READ_LATENCY-1];
        y_out     <= tag_y_reg[READ_LATENCY-1];
        count_reg <= count_reg + (ADDR_W+1)'(1);
      end

      case (state_reg)
        IDLE: begin
          tabulate_out <= 1'b0;
          if (start_in) begin
            state_reg <= SCAN;
            busy_out  <= 1'b1;
            addr_reg  <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
          end
        end
        SCAN: begin
          if (addr_reg == LAST_ADDR) begin
            state_reg <= DRAIN;
            drain_reg <= '0;
            addr_reg  <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
          end else begin
            addr_reg <= addr_reg + ADDR_W'(1);
            if (x_reg == LAST_X) begin
              x_reg <= '0;
              y_reg <= y_reg + 10'd1;
            end else begin
              x_reg <= x_reg + 11'd1;
            end
          end
        end
        DRAIN: begin
          // One extra cycle beyond the flush lets the final registered hit land in count_reg.
          if (drain_reg == DRAIN_END) begin
            state_reg       <= TAB;
            tabulate_out    <= 1'b1;
            pixel_count_out <= count_reg;
            count_reg       <= '0;
          end else begin
            drain_reg <= drain_reg + DRAIN_W'(1);
          end
        end
        TAB: begin
          state_reg    <= IDLE;
          tabulate_out <= 1'b0;
          busy_out     <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_addr_out = addr_reg;

endmodule

// File: tb/tb_mask_scan_streamer.sv
// Scoreboard bench for mask_scan_streamer on an 8x4 frame (latency 2, plus a latency-1 instance).
module tb_mask_scan_streamer;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start1;
  logic [4:0]  addr0, addr1;
  logic        data0, data1;
  logic [10:0] x0, x1;
  logic [9:0]  y0, y1;
  logic        valid0, valid1, tab0, tab1, busy0, busy1;
  logic [5:0]  pcnt0, pcnt1;

  mask_scan_streamer #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(2)) u0 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start0), .mem_addr_out(addr0),
    .mem_data_in(data0), .x_out(x0), .y_out(y0), .valid_out(valid0),
    .tabulate_out(tab0), .busy_out(busy0), .pixel_count_out(pcnt0));

  mask_scan_streamer #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(1)) u1 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start1), .mem_addr_out(addr1),
    .mem_data_in(data1), .x_out(x1), .y_out(y1), .valid_out(valid1),
    .tabulate_out(tab1), .busy_out(busy1), .pixel_count_out(pcnt1));

  // BRAM models
  logic mask [N];
  logic d1, d2, e1;
  always @(posedge clk) begin
    d1 <= mask[addr0];
    d2 <= d1;
    e1 <= mask[addr1];
  end
  assign data0 = d2;
  assign data1 = e1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;
  int v1_seen = 0;

  typedef struct {
    bit tab;
    int x;
    int y;
    int cyc;
    int cnt;
  } exp_t;
  exp_t q[$];

  // Monitor for the latency-2 instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid0 && tab0) begin
        tests++; failed++;
        $display("FAIL overlap cyc=%0d valid and tabulate both high, required never together", cyc);
      end
      if (valid0 || tab0) begin
        tests++;
        if (q.size() == 0) begin
          failed++;
          $display("FAIL unexpected cyc=%0d tab=%0b x=%0d y=%0d, required no output", cyc, tab0, x0, y0);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.tab != tab0 ||
              (!e.tab && (e.x != int'(x0) || e.y != int'(y0))) ||
              (e.tab && e.cnt != int'(pcnt0))) begin
            failed++;
            $display("FAIL event got cyc=%0d tab=%0b x=%0d y=%0d cnt=%0d, required cyc=%0d tab=%0b x=%0d y=%0d cnt=%0d",
                     cyc, tab0, x0, y0, pcnt0, e.cyc, e.tab, e.x, e.y, e.cnt);
          end else begin
            $display("[MON] cyc=%0d tab=%0b x=%0d y=%0d cnt=%0d ok", cyc, tab0, x0, y0, pcnt0);
          end
        end
      end
      if (valid1) v1_seen++;
    end
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      failed++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mask(input int a0, input int a1, input int a2, input int a3);
    for (int k = 0; k < N; k++) mask[k] = (k == a0) || (k == a1) || (k == a2) || (k == a3);
  endtask

  function automatic int mask_count();
    int c = 0;
    for (int k = 0; k < N; k++) if (mask[k]) c++;
    return c;
  endfunction

  // Hand-derived timing: hit at k appears at A+k+3, tabulate at A+35.
  task automatic push_frame(input int a);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        e.tab = 1'b0; e.x = k % W; e.y = k / W; e.cyc = a + k + 3; e.cnt = 0;
        q.push_back(e);
      end
    end
    e.tab = 1'b1; e.x = 0; e.y = 0; e.cyc = a + 35; e.cnt = mask_count();
    q.push_back(e);
  endtask

  task automatic start_frame(output int a);
    @(posedge clk); #1;
    start0 = 1'b1;
    a = cyc + 1;
    push_frame(a);
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  task automatic end_checks(input int a, input int cnt);
    wait_to(a + 35);
    check("busy_at_tab", int'(busy0), 1);
    wait_to(a + 36);
    check("busy_after_tab", int'(busy0), 0);
    check("pixel_count", int'(pcnt0), cnt);
  endtask

  initial begin
    int a, a2;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    set_mask(-1, -1, -1, -1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy0), 0);
    check("rst_valid", int'(valid0), 0);
    check("rst_tab", int'(tab0), 0);
    check("rst_addr", int'(addr0), 0);
    check("rst_pcnt", int'(pcnt0), 0);
    #2 rst_n = 1'b1;

    // single bit at addr 13 -> x=5,y=1 at A+16
    set_mask(13, -1, -1, -1);
    start_frame(a);
    wait_to(a);
    check("busy_start", int'(busy0), 1);
    check("addr_start", int'(addr0), 0);
    end_checks(a, 1);

    // empty mask
    set_mask(-1, -1, -1, -1);
    start_frame(a);
    end_checks(a, 0);

    // all ones
    for (int k = 0; k < N; k++) mask[k] = 1'b1;
    start_frame(a);
    end_checks(a, 32);

    // corners, starts at A+10 and A+35 ignored, A+36 accepted
    set_mask(0, 7, 24, 31);
    start_frame(a);
    wait_to(a + 10); start0 = 1'b1;
    wait_to(a + 11); start0 = 1'b0;
    wait_to(a + 35); start0 = 1'b1;
    wait_to(a + 36); start0 = 1'b0;
    check("busy_after_ignored", int'(busy0), 0);
    check("pcnt_corners", int'(pcnt0), 4);
    start0 = 1'b1;
    a2 = a + 37;
    push_frame(a2);
    wait_to(a + 37); start0 = 1'b0;
    check("busy_restart", int'(busy0), 1);
    end_checks(a2, 4);

    // asynchronous reset mid-scan
    for (int k = 0; k < N; k++) mask[k] = 1'b1;
    start_frame(a);
    wait_to(a + 12);
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(valid0), 0);
    check("arst_busy", int'(busy0), 0);
    check("arst_addr", int'(addr0), 0);
    check("arst_x", int'(x0), 0);
    check("arst_y", int'(y0), 0);
    check("arst_pcnt", int'(pcnt0), 0);
    q.delete();
    #5 rst_n = 1'b1;
    wait_to(a + 50);
    check("arst_idle", int'(busy0), 0);
    set_mask(13, -1, -1, -1);
    start_frame(a);
    end_checks(a, 1);

    // latency-1 instance, bit at addr 31
    set_mask(31, -1, -1, -1);
    @(posedge clk); #1;
    start1 = 1'b1;
    a = cyc + 1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_to(a + 32);
    check("rl1_valid_early", int'(valid1), 0);
    wait_to(a + 33);
    check("rl1_valid", int'(valid1), 1);
    check("rl1_x", int'(x1), 7);
    check("rl1_y", int'(y1), 3);
    wait_to(a + 34);
    check("rl1_tab", int'(tab1), 1);
    check("rl1_valid_off", int'(valid1), 0);
    wait_to(a + 35);
    check("rl1_busy_off", int'(busy1), 0);
    check("rl1_pcnt", int'(pcnt1), 1);
    check("rl1_hits", v1_seen, 1);

    wait_to(cyc + 3);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
